// File: rtl/cache_mem_arbiter.sv
// Shares one downstream memory port between the icache and dcache miss paths.
// One transaction in flight; round-robin on simultaneous requests.
module cache_mem_arbiter #(
  parameter int unsigned offset_width = 2,
  parameter bit          DCACHE_FIRST = 1'b1,
  localparam int unsigned LW = 32 << offset_width
) (
  input  logic          clk,
  input  logic          rstn,

  input  logic          icache_mem_req,
  input  logic [31:0]   icache_mem_addr,
  output logic          mem_icache_addrOK,
  output logic          mem_icache_dataOK,
  output logic [LW-1:0] mem_icache_data,

  input  logic          dcache_mem_req,
  input  logic          dcache_mem_wr,
  input  logic [1:0]    dcache_mem_size,
  input  logic [3:0]    dcache_mem_wstrb,
  input  logic [31:0]   dcache_mem_addr,
  input  logic [31:0]   dcache_mem_wdata,
  output logic          mem_dcache_addrOK,
  output logic          mem_dcache_dataOK,
  output logic [LW-1:0] mem_dcache_data,

  output logic          arb_mem_req,
  output logic          arb_mem_wr,
  output logic [1:0]    arb_mem_size,
  output logic [3:0]    arb_mem_wstrb,
  output logic [31:0]   arb_mem_addr,
  output logic [31:0]   arb_mem_wdata,
  output logic          arb_mem_src,
  input  logic          mem_arb_addrOK,
  input  logic          mem_arb_dataOK,
  input  logic [LW-1:0] mem_arb_data
);

  typedef enum logic [2:0] {StIdle, StIAddr, StIData, StDAddr, StDRdata} state_e;

  state_e state;
  logic   owner;
  logic   rr_pref;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= StIdle;
      owner   <= 1'b0;
      rr_pref <= DCACHE_FIRST;
    end else begin
      unique case (state)
        StIdle: begin
          if (icache_mem_req && dcache_mem_req) begin
            // Winner takes the grant, preference passes to the loser.
            state   <= rr_pref ? StDAddr : StIAddr;
            owner   <= rr_pref;
            rr_pref <= ~rr_pref;
          end else if (icache_mem_req) begin
            state <= StIAddr;
            owner <= 1'b0;
          end else if (dcache_mem_req) begin
            state <= StDAddr;
            owner <= 1'b1;
          end
        end
        StIAddr: begin
          if (mem_arb_addrOK) state <= mem_arb_dataOK ? StIdle : StIData;
        end
        StIData: begin
          if (mem_arb_dataOK) state <= StIdle;
        end
        StDAddr: begin
          // Writes complete on address acceptance; reads may finish in the same cycle.
          if (mem_arb_addrOK) begin
            state <= (dcache_mem_wr || mem_arb_dataOK) ? StIdle : StDRdata;
          end
        end
        StDRdata: begin
          if (mem_arb_dataOK) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    arb_mem_req       = 1'b0;
    arb_mem_wr        = 1'b0;
    arb_mem_size      = 2'd2;
    arb_mem_wstrb     = 4'b0000;
    arb_mem_addr      = 32'h0;
    arb_mem_wdata     = 32'h0;
    mem_icache_addrOK = 1'b0;
    mem_icache_dataOK = 1'b0;
    mem_dcache_addrOK = 1'b0;
    mem_dcache_dataOK = 1'b0;
    unique case (state)
      StIAddr: begin
        arb_mem_req       = 1'b1;
        arb_mem_addr      = icache_mem_addr;
        mem_icache_addrOK = mem_arb_addrOK;
        mem_icache_dataOK = mem_arb_addrOK & mem_arb_dataOK;
      end
      StIData: begin
        mem_icache_dataOK = mem_arb_dataOK;
      end
      StDAddr: begin
        arb_mem_req       = 1'b1;
        arb_mem_wr        = dcache_mem_wr;
        arb_mem_size      = dcache_mem_size;
        arb_mem_wstrb     = dcache_mem_wstrb;
        arb_mem_addr      = dcache_mem_addr;
        arb_mem_wdata     = dcache_mem_wdata;
        mem_dcache_addrOK = mem_arb_addrOK;
        mem_dcache_dataOK = mem_arb_addrOK & mem_arb_dataOK & ~dcache_mem_wr;
      end
      StDRdata: begin
        mem_dcache_dataOK = mem_arb_dataOK;
      end
      default: ;
    endcase
  end

  assign arb_mem_src     = (state != StIdle) & owner;
  assign mem_icache_data = mem_arb_data;
  assign mem_dcache_data = mem_arb_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized and directed bench for cache_mem_arbiter against a transaction-phase model.
module tb_cache_mem_arbiter;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req, d_req, d_wr, m_aok, m_dok;
  logic [31:0]   i_addr, d_addr, d_wdata;
  logic [1:0]    d_size;
  logic [3:0]    d_wstrb;
  logic [LW-1:0] m_data;

  logic          i_aok_o, i_dok_o, d_aok_o, d_dok_o;
  logic [LW-1:0] i_data_o, d_data_o;
  logic          a_req, a_wr, a_src;
  logic [1:0]    a_size;
  logic [3:0]    a_wstrb;
  logic [31:0]   a_addr, a_wdata;

  cache_mem_arbiter #(.offset_width(2), .DCACHE_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .icache_mem_req(i_req), .icache_mem_addr(i_addr),
    .mem_icache_addrOK(i_aok_o), .mem_icache_dataOK(i_dok_o), .mem_icache_data(i_data_o),
    .dcache_mem_req(d_req), .dcache_mem_wr(d_wr), .dcache_mem_size(d_size),
    .dcache_mem_wstrb(d_wstrb), .dcache_mem_addr(d_addr), .dcache_mem_wdata(d_wdata),
    .mem_dcache_addrOK(d_aok_o), .mem_dcache_dataOK(d_dok_o), .mem_dcache_data(d_data_o),
    .arb_mem_req(a_req), .arb_mem_wr(a_wr), .arb_mem_size(a_size), .arb_mem_wstrb(a_wstrb),
    .arb_mem_addr(a_addr), .arb_mem_wdata(a_wdata), .arb_mem_src(a_src),
    .mem_arb_addrOK(m_aok), .mem_arb_dataOK(m_dok), .mem_arb_data(m_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 = no transaction, 1 = address phase, 2 = waiting for read line.
  int   m_phase;
  int   m_owner;
  bit   m_pref;
  logic e_iaok, e_idok, e_daok, e_ddok;

  int   cnt_req, cnt_idok, cnt_ddok, cnt_dside;
  int   src_log[$];

  task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_pref  = 1'b1;
  endtask

  task automatic check_all();
    logic        in_addr;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    in_addr = (m_phase == 1);
    e_wr = 1'b0; e_size = 2'd2; e_wstrb = 4'b0; e_addr = 32'h0; e_wdata = 32'h0;
    if (in_addr && m_owner == 0) e_addr = i_addr;
    if (in_addr && m_owner == 1) begin
      e_wr = d_wr; e_size = d_size; e_wstrb = d_wstrb; e_addr = d_addr; e_wdata = d_wdata;
    end
    e_iaok = in_addr && m_owner == 0 && m_aok;
    e_idok = m_owner == 0 && ((in_addr && m_aok && m_dok) || (m_phase == 2 && m_dok));
    e_daok = in_addr && m_owner == 1 && m_aok;
    e_ddok = m_owner == 1 && ((in_addr && m_aok && m_dok && !d_wr) || (m_phase == 2 && m_dok));
    check_eq("req", a_req, in_addr);
    check_eq("wr", a_wr, e_wr);
    check_eq("size", a_size, e_size);
    check_eq("wstrb", a_wstrb, e_wstrb);
    check_eq("addr", a_addr, e_addr);
    check_eq("wdata", a_wdata, e_wdata);
    check_eq("src", a_src, (m_phase != 0) && m_owner == 1);
    check_eq("i_addrOK", i_aok_o, e_iaok);
    check_eq("i_dataOK", i_dok_o, e_idok);
    check_eq("d_addrOK", d_aok_o, e_daok);
    check_eq("d_dataOK", d_dok_o, e_ddok);
    check_eq("i_data", i_data_o, m_data);
    check_eq("d_data", d_data_o, m_data);
  endtask

  task automatic model_next();
    case (m_phase)
      0: begin
        if (i_req && d_req) begin
          m_owner = m_pref ? 1 : 0;
          m_pref  = !m_pref;
          m_phase = 1;
        end else if (i_req || d_req) begin
          m_owner = d_req ? 1 : 0;
          m_phase = 1;
        end
      end
      1: if (m_aok) m_phase = ((m_owner == 1 && d_wr) || m_dok) ? 0 : 2;
      default: if (m_dok) m_phase = 0;
    endcase
  endtask

  // One clock: inputs already applied at the negedge; check, advance model, wait next negedge.
  task automatic cyc();
    if (!rstn) model_reset();
    #1;
    check_all();
    if (a_req) begin
      cnt_req++;
      src_log.push_back(int'(a_src));
    end
    if (i_dok_o) cnt_idok++;
    if (d_dok_o) cnt_ddok++;
    if (d_aok_o || d_dok_o) cnt_dside++;
    if (rstn) model_next();
    @(negedge clk);
  endtask

  task automatic clear_counts();
    cnt_req = 0; cnt_idok = 0; cnt_ddok = 0; cnt_dside = 0;
    src_log.delete();
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; i_req = 0; d_req = 0; d_wr = 0; m_aok = 0; m_dok = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_size = 0; d_wstrb = 0; m_data = 0;
    model_reset();
    clear_counts();
    @(negedge clk);
    cyc();
    check_eq("reset_size", a_size, 2'd2);
    rstn = 1'b1;
    cyc();

    // Icache-only read: addrOK at cycle 3, dataOK at cycle 6.
    clear_counts();
    i_req = 1; i_addr = 32'h1C00_0040;
    cyc(); cyc(); cyc();
    m_aok = 1; cyc();
    i_req = 0; m_aok = 0; cyc(); cyc();
    m_dok = 1; m_data = {4{32'hA5A5_A5A5}}; cyc();
    m_dok = 0; cyc();
    check_eq("iread_req_cycles", cnt_req, 3);
    check_eq("iread_dataok_cycles", cnt_idok, 1);
    check_eq("iread_dcache_quiet", cnt_dside, 0);

    // Dcache write accepted on the first request cycle.
    clear_counts();
    d_req = 1; d_wr = 1; d_wstrb = 4'b0011; d_size = 2'd1; d_addr = 32'h80;
    d_wdata = 32'hDEAD_BEEF;
    cyc();
    m_aok = 1; m_dok = 1; cyc();
    d_req = 0; m_aok = 0; m_dok = 0; cyc(); cyc();
    check_eq("dwrite_req_cycles", cnt_req, 1);
    check_eq("dwrite_no_dataok", cnt_ddok, 0);

    // Both held: dcache, icache, dcache with an idle gap between grants.
    reset_pulse();
    clear_counts();
    i_req = 1; d_req = 1; d_wr = 0; m_aok = 1; m_dok = 1;
    repeat (6) cyc();
    i_req = 0; d_req = 0; m_aok = 0; m_dok = 0;
    cyc();
    check_eq("rr_grants", src_log.size(), 3);
    if (src_log.size() == 3) begin
      check_eq("rr_first", src_log[0], 1);
      check_eq("rr_second", src_log[1], 0);
      check_eq("rr_third", src_log[2], 1);
    end

    // Dcache read with addrOK and dataOK together.
    clear_counts();
    d_req = 1; d_wr = 0; d_addr = 32'h1234_5678; m_data = {4{32'h0BAD_F00D}};
    cyc();
    m_aok = 1; m_dok = 1; cyc();
    d_req = 0; m_aok = 0; m_dok = 0; cyc();
    m_dok = 1; cyc();
    m_dok = 0;
    check_eq("dread_fast_dataok", cnt_ddok, 1);

    // Spurious dataOK in idle and during the icache address phase.
    clear_counts();
    m_dok = 1; cyc(); cyc();
    i_req = 1; i_addr = 32'h0000_1000; cyc(); cyc(); cyc();
    m_dok = 0; m_aok = 1; cyc();
    i_req = 0; m_aok = 0; m_dok = 1; cyc();
    m_dok = 0; cyc();
    check_eq("spurious_idok", cnt_idok, 1);

    // Reset while waiting for the icache line, then a late dataOK.
    clear_counts();
    i_req = 1; cyc();
    m_aok = 1; cyc();
    i_req = 0; m_aok = 0; cyc();
    rstn = 1'b0; cyc();
    rstn = 1'b1; m_dok = 1; cyc();
    m_dok = 0;
    check_eq("reset_late_dataok", cnt_idok, 0);
    clear_counts();
    i_req = 1; d_req = 1; d_wr = 1; cyc();
    m_aok = 1; cyc();
    d_req = 0; m_aok = 0; cyc();
    i_req = 0; m_aok = 1; cyc();
    m_aok = 0; m_dok = 1; cyc();
    m_dok = 0; cyc();
    if (src_log.size() > 0) check_eq("reset_pref", src_log[0], 1);
    else check_eq("reset_pref_granted", 0, 1);

    // Randomized traffic; requesters hold until their addrOK.
    i_req = 0; d_req = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_req && $urandom_range(3) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(3) == 0) begin
        d_req = 1; d_wr = $urandom_range(1); d_size = 2'($urandom_range(2));
        d_wstrb = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      m_aok  = $urandom_range(1);
      m_dok  = ($urandom_range(2) == 0);
      m_data = {$urandom, $urandom, $urandom, $urandom};
      rstn   = ($urandom_range(400) != 0);
      cyc();
      if (e_iaok) i_req = 0;
      if (e_daok) d_req = 0;
      rstn = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
